// File: rtl/cpu_step_controller.sv
// Run/step sequencer for the single-cycle CPU core: divides the 4x board clock
// into CPU cycles and gates the core's clock-enable by run switch, step button and halt.

module cpu_step_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: a stale cnt_d or level_d would infer a latch, so both get a default first.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_inc == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: rst is sampled on the clock edge like any other input; all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

module cpu_step_controller #(
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ch_n,
  input  logic                    cp_n,
  input  logic                    halt_req,
  output logic                    cpu_ce,
  output logic [$clog2(DIV)-1:0]  phase,
  output logic [1:0]              state,
  output logic                    running,
  output logic [CNT_W-1:0]        cycle_count
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              running_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cp_prev_q;
  logic              ch_db, cp_db;
  logic              boundary;
  logic              step_evt;
  logic              ce;

  cpu_step_debounce #(.DEBOUNCE(DEBOUNCE)) u_ch_db (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (ch_n),
    .level_o (ch_db)
  );

  cpu_step_debounce #(.DEBOUNCE(DEBOUNCE)) u_cp_db (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (cp_n),
    .level_o (cp_db)
  );

  assign boundary = (phase_q == PHASE_LAST);
  assign step_evt = cp_prev_q & ~cp_db;
  // Suppressed during the reset tick so an abandoned cycle never reaches the core.
  assign ce       = ~rst & boundary & ((state_q == ST_RUN) || (state_q == ST_STEP));

  assign phase_d = boundary ? '0 : phase_q + PW'(1);
  assign count_d = (ce && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: begin
        if (!ch_db) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // The cycle in progress always completes; decisions wait for the boundary.
        if (boundary) begin
          if (halt_req) begin
            state_d = ST_STOPPED;
          end else if (ch_db) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_STEP: begin
        if (boundary) begin
          state_d = halt_req ? ST_STOPPED : ST_HOLD;
        end
      end
      ST_STOPPED: begin
        if (ch_db) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      phase_q   <= '0;
      running_q <= 1'b0;
      count_q   <= '0;
      cp_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      running_q <= (state_d == ST_RUN);
      count_q   <= count_d;
      cp_prev_q <= cp_db;
    end
  end

  assign cpu_ce      = ce;
  assign phase       = phase_q;
  assign state       = state_q;
  assign running     = running_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: each expected cpu_ce pulse is queued with the
// cycle_count it must see, and popped when the pulse appears.

module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_n = 1'b1;
  logic        cp_n = 1'b1;
  logic        halt_req = 1'b0;

  logic        cpu_ce;
  logic [1:0]  phase;
  logic [1:0]  state;
  logic        running;
  logic [31:0] cycle_count;

  logic        sat_ce;
  logic [1:0]  sat_phase;
  logic [1:0]  sat_state;
  logic        sat_running;
  logic [3:0]  sat_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt = 0;
  logic [31:0] mon_e;
  logic [1:0]  bphase = 2'd0;

  always #5 clk = ~clk;

  cpu_step_controller #(.DIV(4), .DEBOUNCE(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_n        (ch_n),
    .cp_n        (cp_n),
    .halt_req    (halt_req),
    .cpu_ce      (cpu_ce),
    .phase       (phase),
    .state       (state),
    .running     (running),
    .cycle_count (cycle_count)
  );

  cpu_step_controller #(.DIV(4), .DEBOUNCE(4), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .ch_n        (ch_n),
    .cp_n        (cp_n),
    .halt_req    (halt_req),
    .cpu_ce      (sat_ce),
    .phase       (sat_phase),
    .state       (sat_state),
    .running     (sat_running),
    .cycle_count (sat_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected phase: free-running mod-4 count, cleared by a reset edge.
  always @(posedge clk) bphase <= rst ? 2'd0 : bphase + 2'd1;

  always @(negedge clk) begin
    if (rst) begin
      check("ce_in_reset", 64'(cpu_ce), 64'(0));
    end else begin
      check("phase_seq", 64'(phase), 64'(bphase));
      if (cpu_ce) begin
        if (exp_q.size() == 0) begin
          check("spurious_ce", 64'(cpu_ce), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("ce_count", 64'(cycle_count), 64'(mon_e));
          check("ce_phase", 64'(phase), 64'(3));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int n);
    repeat (n) begin
      exp_q.push_back(exp_cnt);
      exp_cnt++;
    end
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      tick();
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic to_phase(input logic [1:0] p);
    int t = 0;
    while (bphase != p && t < 8) begin
      tick();
      t++;
    end
  endtask

  initial begin
    // Reset and idle: HOLD, no pulses, counter at zero.
    tick(2);
    check("rst_phase", 64'(phase), 64'(0));
    check("rst_state", 64'(state), 64'(0));
    check("rst_count", 64'(cycle_count), 64'(0));
    check("rst_running", 64'(running), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle_state", 64'(state), 64'(0));
      check("idle_count", 64'(cycle_count), 64'(0));
    end

    // Free run for 10 cycles, then release the switch at a phase-0 tick:
    // debounced at +6, so the boundaries at +3 and +7 both still pulse.
    to_phase(2'd0);
    push(10);
    ch_n = 1'b0;
    tick(8);
    check("run_state", 64'(state), 64'(1));
    check("run_running", 64'(running), 64'(1));
    drain(60);
    check("run_count10", 64'(cycle_count), 64'(10));
    to_phase(2'd0);
    push(2);
    ch_n = 1'b1;
    drain(20);
    tick(2);
    check("run_to_hold", 64'(state), 64'(0));
    check("run_count12", 64'(cycle_count), 64'(12));

    // Single step, then a glitch too short to be accepted.
    tick(4);
    push(1);
    cp_n = 1'b0;
    tick(8);
    cp_n = 1'b1;
    drain(20);
    tick(4);
    check("step_state", 64'(state), 64'(0));
    check("step_count", 64'(cycle_count), 64'(13));
    tick(10);
    cp_n = 1'b0;
    tick(3);
    cp_n = 1'b1;
    tick(20);
    check("glitch_state", 64'(state), 64'(0));
    check("glitch_count", 64'(cycle_count), 64'(13));

    // Halt raised at phase 1 of a running cycle: that cycle's pulse still issues.
    to_phase(2'd0);
    push(2);
    ch_n = 1'b0;
    drain(30);
    to_phase(2'd1);
    halt_req = 1'b1;
    push(1);
    drain(10);
    tick(12);
    check("halt_state", 64'(state), 64'(3));
    check("halt_running", 64'(running), 64'(0));
    check("halt_count", 64'(cycle_count), 64'(16));
    halt_req = 1'b0;
    tick(8);
    check("stopped_stays", 64'(state), 64'(3));
    ch_n = 1'b1;
    tick(8);
    check("stopped_to_hold", 64'(state), 64'(0));

    // Run and step accepted in the same tick: run wins.
    to_phase(2'd0);
    push(1);
    ch_n = 1'b0;
    cp_n = 1'b0;
    tick(8);
    check("both_state", 64'(state), 64'(1));
    drain(4);

    // Reset at phase 2 mid-run.
    to_phase(2'd2);
    rst = 1'b1;
    ch_n = 1'b1;
    cp_n = 1'b1;
    tick();
    check("midrst_phase", 64'(phase), 64'(0));
    check("midrst_state", 64'(state), 64'(0));
    check("midrst_count", 64'(cycle_count), 64'(0));
    check("midrst_running", 64'(running), 64'(0));
    exp_cnt = 0;
    rst = 1'b0;

    // Saturation of the 4-bit counter against the 32-bit one.
    tick(2);
    to_phase(2'd0);
    push(20);
    ch_n = 1'b0;
    drain(120);
    check("sat_main20", 64'(cycle_count), 64'(20));
    check("sat_count15", 64'(sat_count), 64'(15));
    push(2);
    ch_n = 1'b1;
    drain(20);
    tick(2);
    check("sat_end_state", 64'(state), 64'(0));
    check("sat_main22", 64'(cycle_count), 64'(22));
    check("sat_hold15", 64'(sat_count), 64'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
